// File: rtl/mio_arb_pkg.sv
// mio_arb_pkg: shared state encoding, owner codes and bus width for the MIO arbiter
package mio_arb_pkg;
  localparam int BUS_W = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_M0 = 2'b01, OWN_M1 = 2'b10} owner_t;
endpackage

// File: rtl/mio_arbiter_if.sv
// mio_arbiter_if: CPU, DMA and memory/IO bus signals of the MIO arbiter
interface mio_arbiter_if;
  import mio_arb_pkg::*;
  logic             m0_req, m0_we, m0_ready, m0_err;
  logic [BUS_W-1:0] m0_addr, m0_wdata, m0_rdata;
  logic             m1_req, m1_we, m1_ready, m1_err;
  logic [BUS_W-1:0] m1_addr, m1_wdata, m1_rdata;
  logic             slv_req, slv_we, slv_ready;
  logic [BUS_W-1:0] slv_addr, slv_wdata, slv_rdata;
  logic [1:0]       owner;
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  slv_rdata, slv_ready,
    output m0_ready, m0_err, m0_rdata,
    output m1_ready, m1_err, m1_rdata,
    output slv_req, slv_we, slv_addr, slv_wdata, owner
  );
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output slv_rdata, slv_ready,
    input  m0_ready, m0_err, m0_rdata,
    input  m1_ready, m1_err, m1_rdata,
    input  slv_req, slv_we, slv_addr, slv_wdata, owner
  );
endinterface

// File: rtl/mio_timeout_cnt.sv
// mio_timeout_cnt: saturating 8-bit BUSY-cycle counter with terminal-count flag
module mio_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (!reset || clr) cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
  assign tc = cnt == 8'(LIMIT);
endmodule

// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master round-robin arbiter for a single memory/IO slave with timeout abort
module mio_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic reset,
  mio_arbiter_if.master bus
);
  import mio_arb_pkg::*;
  state_t state;
  logic   last_grant, pick, tc;
  // on a tie, master 1 wins only if master 0 was granted last
  assign pick = bus.m1_req & (~bus.m0_req | ~last_grant);
  mio_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .en   (state == BUSY),
    .tc   (tc)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      bus.owner     <= OWN_NONE;
      bus.slv_req   <= 1'b0;
      bus.slv_we    <= 1'b0;
      bus.slv_addr  <= '0;
      bus.slv_wdata <= '0;
      bus.m0_ready  <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_ready  <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.m0_req | bus.m1_req) begin
          state         <= BUSY;
          last_grant    <= pick;
          bus.owner     <= pick ? OWN_M1 : OWN_M0;
          bus.slv_req   <= 1'b1;
          bus.slv_we    <= pick ? bus.m1_we : bus.m0_we;
          bus.slv_addr  <= pick ? bus.m1_addr : bus.m0_addr;
          bus.slv_wdata <= pick ? bus.m1_wdata : bus.m0_wdata;
        end
        BUSY: if (bus.slv_ready | tc) begin
          // a ready on the terminal-count cycle still completes the transfer
          state         <= bus.slv_ready ? DONE : ERR;
          bus.slv_req   <= 1'b0;
          bus.slv_we    <= 1'b0;
          bus.slv_addr  <= '0;
          bus.slv_wdata <= '0;
          if (bus.owner == OWN_M1) begin
            bus.m1_ready <= bus.slv_ready;
            bus.m1_err   <= ~bus.slv_ready;
            if (bus.slv_ready & ~bus.slv_we) bus.m1_rdata <= bus.slv_rdata;
          end else begin
            bus.m0_ready <= bus.slv_ready;
            bus.m0_err   <= ~bus.slv_ready;
            if (bus.slv_ready & ~bus.slv_we) bus.m0_rdata <= bus.slv_rdata;
          end
        end
        default: begin
          state        <= IDLE;
          bus.owner    <= OWN_NONE;
          bus.m0_ready <= 1'b0;
          bus.m0_err   <= 1'b0;
          bus.m1_ready <= 1'b0;
          bus.m1_err   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_mio_arbiter;
  import mio_arb_pkg::*;
  localparam int T = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mio_arbiter_if bus();
  mio_arbiter #(.TIMEOUT_CYC(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  int          n_chk = 0, n_err = 0;
  bit          pend[2];
  bit          we_q[2];
  logic [31:0] addr_q[2], wd_q[2], rd_exp[2];
  int          last = 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    bus.m0_req = pend[0]; bus.m0_we = we_q[0]; bus.m0_addr = addr_q[0]; bus.m0_wdata = wd_q[0];
    bus.m1_req = pend[1]; bus.m1_we = we_q[1]; bus.m1_addr = addr_q[1]; bus.m1_wdata = wd_q[1];
  endtask
  task automatic set_req(input int m, input bit we, input logic [31:0] a, input logic [31:0] wd);
    pend[m] = 1'b1; we_q[m] = we; addr_q[m] = a; wd_q[m] = wd;
    drive();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_owner"}, bus.owner, 0);
    check({tag, "_slv"}, {bus.slv_req, bus.slv_we}, 0);
    check({tag, "_addr"}, bus.slv_addr, 0);
    check({tag, "_wdata"}, bus.slv_wdata, 0);
    check({tag, "_pulse"}, {bus.m0_ready, bus.m0_err, bus.m1_ready, bus.m1_err}, 0);
    check({tag, "_rdata0"}, bus.m0_rdata, rd_exp[0]);
    check({tag, "_rdata1"}, bus.m1_rdata, rd_exp[1]);
  endtask
  task automatic stray();
    bus.slv_ready = 1'b1;
    bus.slv_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.slv_ready = 1'b0;
    check_idle("stray");
  endtask
  // d = BUSY cycle on which the slave answers; beyond T+1 the transfer must time out
  task automatic xfer(input int d, input logic [31:0] rdv);
    int w;
    bit ok;
    logic [3:0] ev;
    w = (pend[0] && pend[1]) ? (last == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
    last = w;
    ok = d <= T + 1;
    @(posedge clk);
    for (int i = 1; i <= T + 1; i++) begin
      @(negedge clk);
      check("busy_req", bus.slv_req, 1);
      check("busy_owner", bus.owner, w + 1);
      check("busy_we", bus.slv_we, we_q[w]);
      check("busy_addr", bus.slv_addr, addr_q[w]);
      check("busy_wdata", bus.slv_wdata, wd_q[w]);
      check("busy_pulse", {bus.m0_ready, bus.m0_err, bus.m1_ready, bus.m1_err}, 0);
      bus.slv_ready = i == d;
      bus.slv_rdata = i == d ? rdv : $urandom;
      if (i == d && !we_q[w]) rd_exp[w] = rdv;
      @(posedge clk);
      if (i == d) break;
    end
    @(negedge clk);
    bus.slv_ready = 1'b0;
    ev = {ok && w == 0, !ok && w == 0, ok && w == 1, !ok && w == 1};
    check("end_owner", bus.owner, w + 1);
    check("end_req", bus.slv_req, 0);
    check("end_pulse", {bus.m0_ready, bus.m0_err, bus.m1_ready, bus.m1_err}, ev);
    check("end_rdata0", bus.m0_rdata, rd_exp[0]);
    check("end_rdata1", bus.m1_rdata, rd_exp[1]);
    pend[w] = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    check_idle("idle");
  endtask
  initial begin
    pend = '{0, 0}; we_q = '{0, 0}; addr_q = '{0, 0}; wd_q = '{0, 0}; rd_exp = '{0, 0};
    drive();
    bus.slv_ready = 1'b0;
    bus.slv_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    @(negedge clk);
    stray();
    set_req(0, 1'b0, 32'h0000_0010, 32'h0);
    xfer(3, 32'hDEAD_BEEF);
    check("single_read", bus.m0_rdata, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 32'h0000_C000, 32'h1234_5678);
    xfer(2, $urandom);
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!pend[1]) set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      xfer(1, $urandom);
    end
    xfer(1, $urandom);
    set_req(0, 1'b0, 32'h0000_0020, 32'h0);
    xfer(100, 32'h0);
    stray();
    set_req(0, 1'b0, 32'h0000_0030, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_pre", bus.slv_req, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd_exp = '{0, 0};
    last = 1;
    check_idle("rst_busy");
    reset = 1'b1;
    pend = '{0, 0};
    drive();
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_after");
    set_req(0, 1'b0, 32'h0000_0040, 32'h0);
    xfer(2, 32'hCAFE_F00D);
    for (int n = 0; n < 150; n++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1)
          set_req(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!pend[0] && !pend[1]) stray();
      else xfer($urandom_range(1, 7), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles BUSY waits for slv_ready before abort; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-004 m0_req, m0_we  input  1 each  CPU master request / write-enable.
REQ-005 m0_addr, m0_wdata  input  32 each  CPU address / write data.
REQ-006 m0_ready, m0_err  output  1 each  CPU completion pulse / timeout-error pulse.
REQ-007 m0_rdata  output  32  CPU read data.
REQ-008 m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_err, m1_rdata: same as REQ-004..007, for the DMA/display master.
REQ-009 slv_req  output  1  bus cycle active toward memory/IO.
REQ-010 slv_we  output  1  write strobe to memory/IO.
REQ-011 slv_addr, slv_wdata  output  32 each  registered address / write data.
REQ-012 slv_rdata  input  32  read data from memory/IO.
REQ-013 slv_ready  input  1  memory/IO completion, valid only while slv_req=1.
REQ-014 owner  output  2  00 none, 01 master 0, 10 master 1.

Function
REQ-015 States: IDLE, BUSY, DONE, ERR; one-hot or encoded, all registered.
REQ-016 IDLE, no req: stay IDLE; all slave and master outputs 0.
REQ-017 IDLE, exactly one mN_req=1: next cycle BUSY, owner=N, mN_we/addr/wdata captured into slv_we/slv_addr/slv_wdata.
REQ-018 IDLE, both req=1: grant the master not granted last (round-robin via last_grant register); after reset last_grant=1, so master 0 wins the first tie.
REQ-019 BUSY: slv_req=1; slv_we/addr/wdata held constant; timeout counter increments each cycle.
REQ-020 BUSY, slv_ready=1: capture slv_rdata into owner's mN_rdata; next state DONE.
REQ-021 BUSY, counter reaches TIMEOUT_CYC with slv_ready=0: next state ERR; slv_req drops.
REQ-022 DONE: exactly one cycle; owner's mN_ready=1, slv_req=0; then IDLE, owner=00.
REQ-023 ERR: exactly one cycle; owner's mN_err=1, mN_ready=0, mN_rdata unchanged; then IDLE.
REQ-024 Read latency: req seen in IDLE at cycle t, slave ready at cycle t+k (k>=1), mN_ready at t+k+1.
REQ-025 Non-owner mN_ready/mN_err stay 0; non-owner req ignored until IDLE.
REQ-026 Master holds req and signals stable until its ready/err pulse; req still high in IDLE after DONE is a new request.
REQ-027 mN_rdata holds the last value until overwritten by a completed read of that master.
REQ-028 Timeout counter 8 bits; clears on entry to BUSY; never wraps.
REQ-029 slv_ready outside BUSY ignored.

Reset
REQ-030 reset=0: state IDLE, owner=00, last_grant=1, counter=0, slv_req/slv_we=0, slv_addr/slv_wdata=0, m0/m1 ready/err=0, m0/m1 rdata=0.
REQ-031 Reset mid-BUSY aborts the transfer: slv_req=0 the cycle after the reset edge, no ready/err pulse issued.

Structure
REQ-032 Package mio_arb_pkg holds the state encoding, owner codes (NONE/M0/M1) and bus width constant 32.
REQ-033 One sub-module, mio_timeout_cnt (clear, enable, terminal-count flag); rest inline.

Verification
REQ-034 Single read: m0_req=1, addr=0x0000_0010, slv_ready at 3rd BUSY cycle with slv_rdata=0xDEADBEEF -> m0_ready one cycle later, m0_rdata=0xDEADBEEF, owner back to 00.
REQ-035 Write: m1_req=1, m1_we=1, addr=0x0000_C000, wdata=0x1234_5678 -> slv_we=1, slv_addr/slv_wdata match while BUSY; m1_ready one pulse; m0 outputs unchanged.
REQ-036 Tie sequence: both req held for 4 transfers, slv_ready=1 immediately -> grants M0, M1, M0, M1.
REQ-037 Timeout: TIMEOUT_CYC=4, m0 read, slv_ready never -> m0_err one pulse 5 cycles after BUSY entry, m0_ready=0, m0_rdata unchanged.
REQ-038 Reset mid-BUSY: reset=0 during BUSY with slv_ready=0 -> next cycle IDLE, all outputs at REQ-030 values, no ready pulse; a new m0 read then completes normally.
REQ-039 Stray slv_ready=1 in IDLE -> no state change, no pulses.
